// File: rtl/apb_gpio_slave.sv
// APB3 GPIO slave: DOUT/DIR/DIN/IE/IS register file with a configurable PREADY wait count,
// a two-flop input synchroniser and rising-edge interrupt capture.
module apb_gpio_slave #(
  parameter int GPIO_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0] LAST_WAIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t r_state;
  state_t w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;

  logic [GPIO_W-1:0] r_dout;
  logic [GPIO_W-1:0] r_dir;
  logic [GPIO_W-1:0] r_ie;
  logic [GPIO_W-1:0] r_is;
  logic [GPIO_W-1:0] r_sync1;
  logic [GPIO_W-1:0] r_sync2;
  logic [GPIO_W-1:0] r_prev;
  logic [GPIO_W-1:0] w_rise;

  logic        w_sel_dout;
  logic        w_sel_dir;
  logic        w_sel_din;
  logic        w_sel_ie;
  logic        w_sel_is;
  logic        w_err;
  logic        w_resp;
  logic        w_wr;
  logic [31:0] w_rdata;
  logic        w_unused_bits;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Dropping PSEL in WAIT abandons the transfer before any response or write.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = 4'd0;
        if (PSEL && !PENABLE) begin
          w_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          w_next = ST_IDLE;
        end else if (r_cnt == LAST_WAIT) begin
          w_next = ST_RESP;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_sel_dout = (PADDR[7:0] == 8'h00);
  assign w_sel_dir  = (PADDR[7:0] == 8'h04);
  assign w_sel_din  = (PADDR[7:0] == 8'h08);
  assign w_sel_ie   = (PADDR[7:0] == 8'h0C);
  assign w_sel_is   = (PADDR[7:0] == 8'h10);

  assign w_err  = !(w_sel_dout || w_sel_dir || w_sel_din || w_sel_ie || w_sel_is) ||
                  (PWRITE && w_sel_din);
  assign w_resp = (r_state == ST_RESP);
  assign w_wr   = w_resp && PWRITE && !w_err;

  assign w_unused_bits = ^{PADDR[31:8], PWDATA};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_dout <= '0;
      r_dir  <= '0;
      r_ie   <= '0;
    end else if (w_wr) begin
      if (w_sel_dout) r_dout <= PWDATA[GPIO_W-1:0];
      if (w_sel_dir)  r_dir  <= PWDATA[GPIO_W-1:0];
      if (w_sel_ie)   r_ie   <= PWDATA[GPIO_W-1:0];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;

  // A fresh edge is OR-ed in after the clear so it survives a simultaneous W1C.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_is <= '0;
    end else if (w_wr && w_sel_is) begin
      r_is <= (r_is & ~PWDATA[GPIO_W-1:0]) | w_rise;
    end else begin
      r_is <= r_is | w_rise;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (PADDR[7:0])
      8'h00:   w_rdata[GPIO_W-1:0] = r_dout;
      8'h04:   w_rdata[GPIO_W-1:0] = r_dir;
      8'h08:   w_rdata[GPIO_W-1:0] = r_sync2;
      8'h0C:   w_rdata[GPIO_W-1:0] = r_ie;
      8'h10:   w_rdata[GPIO_W-1:0] = r_is;
      default: w_rdata = '0;
    endcase
  end

  assign PREADY   = w_resp;
  assign PSLVERR  = w_resp && w_err;
  assign PRDATA   = (w_resp && !PWRITE) ? w_rdata : 32'd0;
  assign gpio_out = r_dout;
  assign gpio_oe  = r_dir;
  assign irq      = |(r_is & r_ie);

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave (GPIO_W=32, WAIT_STATES=1): register access, error
// responses, edge interrupts, W1C races, aborted transfers and mid-transfer reset.
module tb_apb_gpio_slave;

  localparam int GPIO_W = 32;
  localparam int WS     = 1;

  logic              PCLK;
  logic              PRESET;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic [GPIO_W-1:0] gpio_oe;
  logic              irq;

  int checks = 0;
  int errors = 0;

  apb_gpio_slave #(.GPIO_W(GPIO_W), .WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    PSEL    = sel;
    PENABLE = en;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends RESP.
  // acc is the access cycle in which PREADY was first seen high (0 on timeout).
  task automatic apbXfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] rdata, output logic err, output int acc);
    applyStimulus(1'b1, 1'b0, wr, addr, data);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    acc   = 0;
    rdata = 32'hDEAD_BEEF;
    err   = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) begin
        acc   = i;
        rdata = PRDATA;
        err   = PSLVERR;
        break;
      end
    end
    @(posedge PCLK); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic expErr);
    logic [31:0] rd;
    logic        er;
    int          acc;
    apbXfer(1'b1, addr, data, rd, er, acc);
    checkOutput({tag, "/ready_cycle"}, acc, WS + 1);
    checkOutput({tag, "/pslverr"}, {31'd0, er}, {31'd0, expErr});
    checkOutput({tag, "/prdata_zero"}, rd, 32'd0);
  endtask

  task automatic doRead(input string tag, input logic [31:0] addr, input logic [31:0] expData,
                        input logic expErr);
    logic [31:0] rd;
    logic        er;
    int          acc;
    apbXfer(1'b0, addr, 32'd0, rd, er, acc);
    checkOutput({tag, "/ready_cycle"}, acc, WS + 1);
    checkOutput({tag, "/pslverr"}, {31'd0, er}, {31'd0, expErr});
    checkOutput({tag, "/prdata"}, rd, expData);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    PRESET  = 1'b1;
    gpio_in = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #12;
    checkOutput("reset/pready", {31'd0, PREADY}, 32'd0);
    checkOutput("reset/prdata", PRDATA, 32'd0);
    checkOutput("reset/gpio_out", gpio_out, 32'd0);
    checkOutput("reset/gpio_oe", gpio_oe, 32'd0);
    checkOutput("reset/irq", {31'd0, irq}, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Basic register writes and readback.
    doWrite("wr_dout", 32'h0000_0000, 32'h0000_00A5, 1'b0);
    checkOutput("wr_dout/gpio_out", gpio_out, 32'h0000_00A5);
    doRead("rd_dout", 32'h0000_0000, 32'h0000_00A5, 1'b0);
    doWrite("wr_dir", 32'hABCD_1204, 32'h0000_0F0F, 1'b0);
    checkOutput("wr_dir/gpio_oe", gpio_oe, 32'h0000_0F0F);
    doRead("rd_dir", 32'h0000_0004, 32'h0000_0F0F, 1'b0);

    // Error responses.
    doRead("rd_unmapped", 32'h0000_0044, 32'd0, 1'b1);
    gpio_in = 32'h0000_1234;
    doWrite("wr_din", 32'h0000_0008, 32'hFFFF_FFFF, 1'b1);
    checkOutput("wr_din/gpio_out_kept", gpio_out, 32'h0000_00A5);
    doRead("rd_din", 32'h0000_0008, 32'h0000_1234, 1'b0);
    doRead("rd_is_initial", 32'h0000_0010, 32'h0000_1234, 1'b0);
    doWrite("clr_is_all", 32'h0000_0010, 32'hFFFF_FFFF, 1'b0);
    doRead("rd_is_cleared", 32'h0000_0010, 32'd0, 1'b0);

    // Edge interrupt on bit 3 and W1C clear.
    doWrite("wr_ie", 32'h0000_000C, 32'h0000_0008, 1'b0);
    checkOutput("ie/irq_idle", {31'd0, irq}, 32'd0);
    gpio_in[3] = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    checkOutput("edge/irq_early", {31'd0, irq}, 32'd0);
    @(posedge PCLK); #1;
    checkOutput("edge/irq_set", {31'd0, irq}, 32'd1);
    doRead("rd_is_bit3", 32'h0000_0010, 32'h0000_0008, 1'b0);
    doWrite("clr_is3", 32'h0000_0010, 32'h0000_0008, 1'b0);
    checkOutput("clr_is3/irq", {31'd0, irq}, 32'd0);
    doRead("rd_is_after_clr", 32'h0000_0010, 32'd0, 1'b0);

    // New edge reaches the detector during the RESP cycle of the clearing write.
    gpio_in[3] = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    gpio_in[3] = 1'b1;
    doWrite("race_clr", 32'h0000_0010, 32'h0000_0008, 1'b0);
    checkOutput("race/irq", {31'd0, irq}, 32'd1);
    doRead("race/rd_is", 32'h0000_0010, 32'h0000_0008, 1'b0);
    doWrite("race_cleanup", 32'h0000_0010, 32'h0000_0008, 1'b0);
    checkOutput("race_cleanup/irq", {31'd0, irq}, 32'd0);

    // Aborted write to DIR.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_00FF);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    checkOutput("abort/pready_wait", {31'd0, PREADY}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      checkOutput("abort/pready_after", {31'd0, PREADY}, 32'd0);
    end
    @(posedge PCLK); #1;
    checkOutput("abort/gpio_oe", gpio_oe, 32'h0000_0F0F);
    doRead("abort/rd_dir", 32'h0000_0004, 32'h0000_0F0F, 1'b0);

    // Reset during WAIT with irq and outputs active.
    doWrite("pre_rst_dout", 32'h0000_0000, 32'h0000_00FF, 1'b0);
    checkOutput("pre_rst/gpio_out", gpio_out, 32'h0000_00FF);
    gpio_in[3] = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    gpio_in[3] = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("pre_rst/irq", {31'd0, irq}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0055);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESET  = 1'b1;
    gpio_in = '0;
    #1;
    checkOutput("rst/gpio_out", gpio_out, 32'd0);
    checkOutput("rst/gpio_oe", gpio_oe, 32'd0);
    checkOutput("rst/pready", {31'd0, PREADY}, 32'd0);
    checkOutput("rst/pslverr", {31'd0, PSLVERR}, 32'd0);
    checkOutput("rst/prdata", PRDATA, 32'd0);
    checkOutput("rst/irq", {31'd0, irq}, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      checkOutput("post_rst/penable_in_idle", {31'd0, PREADY}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge PCLK); #1;
    doWrite("post_rst_dout", 32'h0000_0000, 32'h0000_003C, 1'b0);
    checkOutput("post_rst/gpio_out", gpio_out, 32'h0000_003C);
    doRead("post_rst/rd_dir", 32'h0000_0004, 32'd0, 1'b0);
    doRead("post_rst/rd_ie", 32'h0000_000C, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_gpio_slave.md
APB_GPIO_SLAVE -- requirements
Module: apb_gpio_slave

Interface
REQ-001 SHALL have parameter GPIO_W, default 32, giving the number of GPIO pins (1..32).
REQ-002 SHALL have parameter WAIT_STATES, default 1, giving the number of access-phase cycles with PREADY low before PREADY high (0..15).
REQ-003 SHALL have port PCLK, input, 1 bit: the only clock; all flops on its rising edge.
REQ-004 SHALL have port PRESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port PSEL, input, 1 bit: APB slave select.
REQ-006 SHALL have port PENABLE, input, 1 bit: APB access phase.
REQ-007 SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port PADDR, input, 32 bits: byte address.
REQ-009 SHALL have port PWDATA, input, 32 bits: write data.
REQ-010 SHALL have port PRDATA, output, 32 bits: read data.
REQ-011 SHALL have port PREADY, output, 1 bit: transfer completion, registered.
REQ-012 SHALL have port PSLVERR, output, 1 bit: error response, valid only while PREADY=1.
REQ-013 SHALL have port gpio_in, input, GPIO_W bits: asynchronous pin inputs.
REQ-014 SHALL have port gpio_out, output, GPIO_W bits: pin output values.
REQ-015 SHALL have port gpio_oe, output, GPIO_W bits: per-pin output enable, 1 = drive.
REQ-016 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-017 SHALL decode PADDR[7:0] as follows: 0x00 DOUT RW; 0x04 DIR RW; 0x08 DIN RO; 0x0C IE RW; 0x10 IS W1C.
REQ-018 SHALL treat PADDR[31:8] as don't-care; register bits at or above GPIO_W SHALL read 0 and ignore writes.
REQ-019 SHALL implement an FSM with states IDLE, WAIT and RESP; PREADY SHALL be 1 only in RESP.
REQ-020 IDLE SHALL go to WAIT when PSEL=1 and PENABLE=0 (setup cycle); if WAIT_STATES=0 it SHALL go directly to RESP instead.
REQ-021 WAIT SHALL count cycles and go to RESP after exactly WAIT_STATES cycles, so PREADY rises in access cycle WAIT_STATES+1.
REQ-022 RESP SHALL last exactly one cycle and then return to IDLE; back-to-back transfers SHALL be accepted with their setup cycle directly after RESP.
REQ-023 If PSEL=0 during WAIT (aborted transfer), the FSM SHALL return to IDLE with no register write and no PREADY pulse.
REQ-024 PENABLE=1 while in IDLE (protocol violation) SHALL be ignored and leave the FSM in IDLE.
REQ-025 A write SHALL commit on the rising edge that ends the RESP cycle, using PADDR/PWDATA sampled in that cycle.
REQ-026 During RESP with PWRITE=0, PRDATA SHALL present the addressed register; at all other times PRDATA SHALL be 0.
REQ-027 An unmapped address, or a write to DIN, SHALL set PSLVERR=1 in RESP, SHALL cause no register change, and SHALL read 0.
REQ-028 gpio_in SHALL pass through a 2-flop synchroniser; DIN SHALL read the synchronised value, 2 cycles of latency.
REQ-029 IS[i] SHALL set on a synchronised rising edge of gpio_in[i] (previous 0, current 1).
REQ-030 Writing 1 to IS[i] SHALL clear IS[i]; if the clear and a new edge occur in the same cycle, set SHALL win.
REQ-031 gpio_out SHALL equal DOUT and gpio_oe SHALL equal DIR, updated the cycle after the write commits.
REQ-032 irq SHALL equal the OR-reduction of (IS AND IE), driven from registers with no added latency.

Reset
REQ-033 PRESET=1 SHALL immediately force: FSM to IDLE; wait counter, DOUT, DIR, IE, IS and the synchroniser flops to 0; PREADY, PSLVERR, PRDATA, gpio_out, gpio_oe and irq to 0.
REQ-034 Reset asserted mid-transfer SHALL discard the transfer; after release, the FSM SHALL wait for a fresh setup cycle.

Verification
REQ-035 With WAIT_STATES=1, write 0xA5 to 0x00: PREADY SHALL be 0 in access cycle 1 and 1 in cycle 2; gpio_out SHALL be 0x000000A5 on the next cycle.
REQ-036 Read 0x44 (unmapped): PREADY=1 with PSLVERR=1 and PRDATA=0; a write to 0x08 SHALL give PSLVERR=1 and leave DIN unchanged.
REQ-037 Raise gpio_in[3] 0->1 with IE=0x8: IS SHALL read 0x8 and irq SHALL be 1 within 3 cycles; writing 0x8 to 0x10 SHALL clear irq.
REQ-038 Write 1 to IS[3] in the same cycle a new rising edge of bit 3 is detected: IS[3] SHALL remain 1.
REQ-039 Drop PSEL during WAIT of a write of 0xFF to 0x04: DIR SHALL remain unchanged and PREADY SHALL stay 0.
REQ-040 Assert PRESET during WAIT after DOUT=0xFF: all outputs SHALL be 0 asynchronously, and the next full transfer SHALL complete normally.
